en_seq: RTL and testbench

EN_SEQ -- requirements
Module: en_seq

---
 rtl/en_seq.sv | 130 +++++++++++++
 tb/tb_en_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/en_seq.sv
// Enable burst sequencer: emits reps bursts of on_len enable-high cycles
// separated by off_len enable-low gaps, with abort and completion pulse.
module en_seq #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] on_len,
    input  logic [CW-1:0] off_len,
    input  logic [3:0]    reps,
    output logic          en,
    output logic          busy,
    output logic          done,
    output logic [3:0]    rep_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [CW-1:0]   on_len_r, on_len_s;
    logic [CW-1:0]   off_len_r, off_len_s;
    logic [3:0]      reps_r, reps_s;
    logic [3:0]      rep_cnt_s;
    logic            done_s;

    // Next-state, counter and parameter-latch logic
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        on_len_s  = on_len_r;
        off_len_s = off_len_r;
        reps_s    = reps_r;
        rep_cnt_s = rep_cnt;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    on_len_s  = on_len;
                    off_len_s = off_len;
                    reps_s    = reps;
                    rep_cnt_s = 4'd0;
                    if ((on_len == CNT_ZERO) || (reps == 4'd0)) begin
                        done_s = 1'b1;
                    end else begin
                        state_s = ON;
                        cnt_s   = on_len;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ON: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (cnt_r == CNT_ONE) begin
                    // Last cycle of a burst: count it, then finish, gap or re-burst
                    rep_cnt_s = rep_cnt + 4'd1;
                    if (rep_cnt_s == reps_r) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else if (off_len_r != CNT_ZERO) begin
                        state_s = OFF;
                        cnt_s   = off_len_r;
                    end else begin
                        cnt_s = on_len_r;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            OFF: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (cnt_r == CNT_ONE) begin
                    state_s = ON;
                    cnt_s   = on_len_r;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and latched-parameter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            on_len_r  <= CNT_ZERO;
            off_len_r <= CNT_ZERO;
            reps_r    <= 4'd0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            on_len_r  <= on_len_s;
            off_len_r <= off_len_s;
            reps_r    <= reps_s;
        end
    end

    // Output registers, decoded from next state so they align with state_r
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rep_cnt <= 4'd0;
        end else begin
            en      <= (state_s == ON);
            busy    <= (state_s != IDLE);
            done    <= done_s;
            rep_cnt <= rep_cnt_s;
        end
    end

endmodule

// File: tb/tb_en_seq.sv
// Directed self-checking bench for en_seq; cycle k is the interval after
// rising edge k-1, with start sampled at edge 0.
module tb_en_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] on_len;
    logic [7:0] off_len;
    logic [3:0] reps;
    logic       en;
    logic       busy;
    logic       done;
    logic [3:0] rep_cnt;

    int n_cmp;
    int n_bad;

    en_seq #(.CW(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .on_len  (on_len),
        .off_len (off_len),
        .reps    (reps),
        .en      (en),
        .busy    (busy),
        .done    (done),
        .rep_cnt (rep_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue start at the next edge (edge 0), then scramble the inputs.
    task automatic kick(input logic [7:0] on_v, input logic [7:0] off_v, input logic [3:0] reps_v);
        @(negedge clk);
        on_len  = on_v;
        off_len = off_v;
        reps    = reps_v;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        on_len  = 8'd7;
        off_len = 8'd9;
        reps    = 4'd15;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        got = {en, busy, done, rep_cnt};
        n_cmp++;
        if (got !== 7'b0) begin
            n_bad++;
            $display("FAIL reset: got %b expected %b", got, 7'b0);
        end
    endtask

    task automatic test_basic();
        logic [6:0] got, exp;
        kick(8'd3, 8'd2, 4'd2);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            exp = {((k >= 1 && k <= 3) || (k >= 6 && k <= 8)), (k >= 1 && k <= 8), (k == 9),
                   (k >= 9) ? 4'd2 : ((k >= 4) ? 4'd1 : 4'd0)};
            got = {en, busy, done, rep_cnt};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL basic cycle %0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_continuous();
        logic [6:0] got, exp;
        kick(8'd2, 8'd0, 4'd3);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp = {(k <= 6), (k <= 6), (k == 7),
                   (k >= 7) ? 4'd3 : ((k >= 5) ? 4'd2 : ((k >= 3) ? 4'd1 : 4'd0))};
            got = {en, busy, done, rep_cnt};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL continuous cycle %0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_zero_len();
        logic [6:0] got, exp;
        kick(8'd0, 8'd3, 4'd5);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            exp = {1'b0, 1'b0, (k == 1), 4'd0};
            got = {en, busy, done, rep_cnt};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL zero_len cycle %0d: got %b expected %b", k, got, exp);
            end
        end
        kick(8'd3, 8'd1, 4'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            exp = {1'b0, 1'b0, (k == 1), 4'd0};
            got = {en, busy, done, rep_cnt};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL zero_reps cycle %0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_abort();
        logic [6:0] got, exp;
        kick(8'd4, 8'd4, 4'd3);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp = {(k <= 4), (k <= 6), 1'b0, (k >= 5) ? 4'd1 : 4'd0};
            got = {en, busy, done, rep_cnt};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL abort cycle %0d: got %b expected %b", k, got, exp);
            end
            abort = (k == 6);
        end
        // abort and start together in IDLE: start is dropped, rep_cnt untouched
        @(negedge clk);
        on_len = 8'd2;
        reps   = 4'd1;
        start  = 1'b1;
        abort  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            exp = {1'b0, 1'b0, 1'b0, 4'd1};
            got = {en, busy, done, rep_cnt};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL abort_start cycle %0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [6:0] got, exp;
        kick(8'd5, 8'd0, 4'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp = {(k <= 5), (k <= 5), (k == 6), (k >= 6) ? 4'd1 : 4'd0};
            got = {en, busy, done, rep_cnt};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL ignore_start cycle %0d: got %b expected %b", k, got, exp);
            end
            if (k == 2) begin
                start  = 1'b1;
                on_len = 8'd1;
                reps   = 4'd2;
            end else begin
                start  = 1'b0;
            end
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] got, exp;
        kick(8'd3, 8'd2, 4'd2);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
        end
        exp = {1'b1, 1'b1, 1'b0, 4'd1};
        got = {en, busy, done, rep_cnt};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL pre_reset: got %b expected %b", got, exp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = {en, busy, done, rep_cnt};
        n_cmp++;
        if (got !== 7'b0) begin
            n_bad++;
            $display("FAIL async_reset: got %b expected %b", got, 7'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        on_len  = 8'd0;
        off_len = 8'd0;
        reps    = 4'd0;
        #23;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
        test_continuous();
        test_zero_len();
        test_abort();
        test_ignore_start();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
